// File: rtl/deframer_pkg.sv
// Shared definitions for the packet deframer: parser state encoding,
// per-packet status codes and the default start-of-frame marker.
package deframer_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHK     = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/deframer_skid.sv
// Two-entry output buffer holding payload bytes with their last flag.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   push_i, push_data_i,
//   push_last_i              write one entry
//   ready_i                  downstream accepts the head entry
//   valid_o, data_o, last_o  head entry (registered)
//   count_o                  occupancy, 0..2
module deframer_skid (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       push_last_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       last_o,
  output logic [1:0] count_o
);

  logic [8:0] ent0_q;
  logic [8:0] ent1_q;
  logic [1:0] count_q;
  logic       pop;
  logic [8:0] push_ent;

  assign pop      = (count_q != 2'd0) && ready_i;
  assign push_ent = {push_last_i, push_data_i};

  // ent0_q is always the head; ent1_q only holds data when count_q == 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= '0;
    end else begin
      unique case ({push_i, pop})
        2'b01: begin
          ent0_q  <= ent1_q;
          count_q <= count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) ent0_q <= push_ent;
          else                 ent1_q <= push_ent;
          count_q <= count_q + 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_q <= push_ent;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= push_ent;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = ent0_q[7:0];
  assign last_o  = ent0_q[8];
  assign count_o = count_q;

  // The read-credit rule upstream must never let the buffer overflow.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop && (count_q == 2'd2)));

endmodule

// File: rtl/pkt_deframer.sv
// Packet deframer: pops bytes from an upstream byte FIFO, hunts for SOF,
// parses LEN, streams the payload on a valid/ready port, verifies the
// trailing checksum (LEN + payload, mod 256) and keeps status counters.
// Ports:
//   clk, srst_n                      clock, asynchronous active-low reset
//   fifo_dout, fifo_empty,
//   fifo_rd_en                       upstream FIFO (data one cycle after read)
//   out_data, out_valid, out_last,
//   out_ready                        payload stream
//   pkt_done, pkt_err                per-frame status pulse and code
//   good_cnt, err_cnt                saturating frame counters
module pkt_deframer
  import deframer_pkg::*;
#(
  parameter logic [7:0]  SOF     = SOF_DEFAULT,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic [7:0]       fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             pkt_done,
  output logic [1:0]       pkt_err,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned     IDLE_W     = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [7:0]      MAX_LEN_B  = 8'(MAX_LEN);

  state_e             state_q;
  logic               inflight_q;
  logic [7:0]         remaining_q;
  logic [7:0]         sum_q;
  logic [IDLE_W-1:0]  idle_q;
  logic               pkt_done_q;
  logic [1:0]         pkt_err_q;
  logic [CNT_W-1:0]   good_q;
  logic [CNT_W-1:0]   err_q;

  logic [1:0]         skid_count;
  logic               skid_push;
  logic               frame_end;
  logic [1:0]         frame_code;

  // Credit counts the byte still in flight from the FIFO, whatever state consumes it.
  assign fifo_rd_en = srst_n && !fifo_empty &&
                      (({1'b0, skid_count} + {2'b00, inflight_q}) < 3'd2);

  assign skid_push = inflight_q && (state_q == PAYLOAD);

  // End-of-frame decision; timeout fires on the TIMEOUT-th consecutive idle cycle.
  always_comb begin
    frame_end  = 1'b0;
    frame_code = ERR_NONE;
    if (inflight_q) begin
      unique case (state_q)
        LEN: begin
          if ((fifo_dout == 8'd0) || (fifo_dout > MAX_LEN_B)) begin
            frame_end  = 1'b1;
            frame_code = ERR_LEN;
          end
        end
        CHK: begin
          frame_end  = 1'b1;
          frame_code = (fifo_dout == sum_q) ? ERR_NONE : ERR_CHK;
        end
        default: ;
      endcase
    end else if ((state_q != HUNT) && (idle_q == IDLE_LAST)) begin
      frame_end  = 1'b1;
      frame_code = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q     <= HUNT;
      inflight_q  <= 1'b0;
      remaining_q <= '0;
      sum_q       <= '0;
      idle_q      <= '0;
      pkt_done_q  <= 1'b0;
      pkt_err_q   <= ERR_NONE;
      good_q      <= '0;
      err_q       <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      pkt_done_q <= frame_end;
      idle_q     <= ((state_q == HUNT) || inflight_q) ? '0 : idle_q + IDLE_W'(1);
      if (frame_end) begin
        pkt_err_q <= frame_code;
        state_q   <= HUNT;
        if (frame_code == ERR_NONE) begin
          if (good_q != '1) good_q <= good_q + CNT_W'(1);
        end else begin
          if (err_q != '1) err_q <= err_q + CNT_W'(1);
        end
      end else if (inflight_q) begin
        unique case (state_q)
          HUNT: if (fifo_dout == SOF) state_q <= LEN;
          LEN: begin
            remaining_q <= fifo_dout;
            sum_q       <= fifo_dout;
            state_q     <= PAYLOAD;
          end
          PAYLOAD: begin
            sum_q       <= sum_q + fifo_dout;
            remaining_q <= remaining_q - 8'd1;
            if (remaining_q == 8'd1) state_q <= CHK;
          end
          default: ;
        endcase
      end
    end
  end

  deframer_skid u_skid (
    .clk         (clk),
    .rst_n       (srst_n),
    .push_i      (skid_push),
    .push_data_i (fifo_dout),
    .push_last_i (remaining_q == 8'd1),
    .ready_i     (out_ready),
    .valid_o     (out_valid),
    .data_o      (out_data),
    .last_o      (out_last),
    .count_o     (skid_count)
  );

  assign pkt_done = pkt_done_q;
  assign pkt_err  = pkt_err_q;
  assign good_cnt = good_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_pkt_deframer.sv
// Self-checking bench for pkt_deframer: a byte-FIFO model feeds frames,
// expected beats and per-frame status go to queues and are compared as
// the DUT produces them.
module tb_pkt_deframer;

  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned CNT_W   = 16;

  typedef struct packed {
    logic [1:0] err;
    logic       chk_time;
  } stat_t;

  logic             clk = 1'b0;
  logic             srst_n;
  logic [7:0]       fifo_dout = 8'h00;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             pkt_done;
  logic [1:0]       pkt_err;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] err_cnt;

  pkt_deframer #(
    .SOF     (8'hA5),
    .MAX_LEN (64),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .srst_n     (srst_n),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err),
    .good_cnt   (good_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Upstream FIFO model
  logic [7:0] src_mem [0:1023];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         cyc = 0;
  int         last_rd_cyc = 0;
  logic       rd_seen = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_seen) begin
      fifo_dout   <= src_mem[rd_ptr];
      rd_ptr      <= rd_ptr + 1;
      last_rd_cyc <= cyc + 1;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    src_mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  // Scoreboard
  logic [8:0] exp_beats [$];
  stat_t      exp_status [$];
  logic [7:0] pl [$];
  int         beats_seen = 0;
  int         mgood = 0;
  int         merr  = 0;
  logic [8:0] eb;
  stat_t      es;

  always @(negedge clk) begin
    rd_seen = fifo_rd_en && !fifo_empty;
    if (srst_n) begin
      if (out_valid && out_ready) begin
        check_eq("beat_expected", 32'(exp_beats.size() > 0), 32'd1);
        if (exp_beats.size() > 0) begin
          eb = exp_beats.pop_front();
          check_eq("beat_data", 32'(out_data), 32'(eb[7:0]));
          check_eq("beat_last", 32'(out_last), 32'(eb[8]));
        end
        beats_seen++;
      end
      if (pkt_done) begin
        check_eq("done_expected", 32'(exp_status.size() > 0), 32'd1);
        if (exp_status.size() > 0) begin
          es = exp_status.pop_front();
          check_eq("pkt_err", 32'(pkt_err), 32'(es.err));
          if (es.err == 2'd0) mgood++;
          else                merr++;
          check_eq("good_cnt", 32'(good_cnt), 32'(mgood));
          check_eq("err_cnt", 32'(err_cnt), 32'(merr));
          if (es.chk_time)
            check_eq("timeout_cycle", 32'(cyc), 32'(last_rd_cyc + 1 + int'(TIMEOUT)));
        end
      end
    end
  end

  // Sends SOF, LEN=pl.size(), pl, checksum xor chk_xor
  task automatic send_frame(input logic [7:0] chk_xor);
    int         n;
    logic [7:0] sum;
    stat_t      st;
    n   = pl.size();
    sum = 8'(n);
    push_byte(8'hA5);
    push_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      push_byte(pl[i]);
      sum = sum + pl[i];
      exp_beats.push_back({(i == n - 1), pl[i]});
    end
    push_byte(sum ^ chk_xor);
    st.err      = (chk_xor != 8'h00) ? 2'd2 : 2'd0;
    st.chk_time = 1'b0;
    exp_status.push_back(st);
  endtask

  task automatic push_status(input logic [1:0] err, input logic chk_time);
    stat_t st;
    st.err      = err;
    st.chk_time = chk_time;
    exp_status.push_back(st);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_beats.size() != 0 || exp_status.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drain"}, 32'(exp_beats.size() + exp_status.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] hold;
  int         start;
  int         n;

  initial begin
    srst_n    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_done", 32'(pkt_done), 32'd0);
    check_eq("rst_good", 32'(good_cnt), 32'd0);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    drive_edge();
    srst_n = 1'b1;

    // Good frame
    drive_edge();
    pl = '{8'h10, 8'h20, 8'h30};
    send_frame(8'h00);
    wait_drain("good1", 200);

    // Bad checksum (A5 02 01 02 00), then a good frame with SOF byte as payload
    drive_edge();
    pl = '{8'h01, 8'h02};
    send_frame(8'h05);
    wait_drain("badchk", 200);
    drive_edge();
    pl = '{8'hA5, 8'h01};
    send_frame(8'h00);
    wait_drain("good2", 200);

    // Garbage then LEN=0, then LEN=65
    drive_edge();
    push_byte(8'h00); push_byte(8'hFF); push_byte(8'hA5); push_byte(8'h00);
    push_status(2'd1, 1'b0);
    wait_drain("len0", 200);
    drive_edge();
    push_byte(8'hA5); push_byte(8'h41);
    push_status(2'd1, 1'b0);
    wait_drain("len65", 200);

    // LEN = MAX_LEN is legal
    drive_edge();
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'($urandom_range(0, 255)));
    send_frame(8'h00);
    wait_drain("maxlen", 600);

    // Backpressure during an 8-byte payload
    drive_edge();
    pl = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
    send_frame(8'h00);
    start = beats_seen;
    n = 0;
    while (beats_seen < start + 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_start", 32'(beats_seen >= start + 3), 32'd1);
    drive_edge();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) hold = out_data;
      if (i >= 3) begin
        check_eq("bp_valid", 32'(out_valid), 32'd1);
        check_eq("bp_stable", 32'(out_data), 32'(hold));
        check_eq("bp_rd_stop", 32'(fifo_rd_en), 32'd0);
      end
    end
    drive_edge();
    out_ready = 1'b1;
    wait_drain("bp", 300);

    // Timeout after A5 04 11
    drive_edge();
    push_byte(8'hA5); push_byte(8'h04); push_byte(8'h11);
    exp_beats.push_back({1'b0, 8'h11});
    push_status(2'd3, 1'b1);
    wait_drain("timeout", int'(TIMEOUT) + 100);
    drive_edge();
    pl = '{8'h07, 8'h70};
    send_frame(8'h00);
    wait_drain("after_to", 200);

    // Reset mid-PAYLOAD with beats held in the buffer
    drive_edge();
    out_ready = 1'b0;
    push_byte(8'hA5); push_byte(8'h05); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    check_eq("pre_rst_data", 32'(out_data), 32'h01);
    @(posedge clk);
    #2;
    srst_n = 1'b0;
    exp_beats.delete();
    exp_status.delete();
    mgood = 0;
    merr  = 0;
    #1;
    check_eq("arst_valid", 32'(out_valid), 32'd0);
    check_eq("arst_data", 32'(out_data), 32'd0);
    check_eq("arst_last", 32'(out_last), 32'd0);
    check_eq("arst_done", 32'(pkt_done), 32'd0);
    check_eq("arst_err", 32'(pkt_err), 32'd0);
    check_eq("arst_good", 32'(good_cnt), 32'd0);
    check_eq("arst_errcnt", 32'(err_cnt), 32'd0);
    check_eq("arst_rd_en", 32'(fifo_rd_en), 32'd0);
    repeat (3) @(negedge clk);
    drive_edge();
    srst_n    = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("post_rst_good", 32'(good_cnt), 32'd0);
    drive_edge();
    pl = '{8'h3C, 8'hC3, 8'h5A};
    send_frame(8'h00);
    wait_drain("post_rst", 200);
    check_eq("final_good", 32'(good_cnt), 32'd1);
    check_eq("final_err", 32'(err_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
